// File: rtl/param_usr_if.sv
// Handshake/data bundle for param_usr: mode/data/burst request in, register and status out.
interface param_usr_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic [2:0]       mode;
    logic [WIDTH-1:0] pload;
    logic             lftin;
    logic             rghtin;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             sout_r;
    logic             sout_l;

    modport master (
        output mode, pload, lftin, rghtin, start, count,
        input  out, busy, done, sout_r, sout_l
    );

    modport slave (
        input  mode, pload, lftin, rghtin, start, count,
        output out, busy, done, sout_r, sout_l
    );
endinterface

// File: rtl/param_usr.sv
// Universal shift register with single-step modes and counted shift bursts.
module param_usr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    param_usr_if.slave bus
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_ROR  = 3'b100,
        M_ROL  = 3'b101,
        M_ASR  = 3'b110,
        M_RSV  = 3'b111
    } mode_t;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t           r_state;
    mode_t            r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_done;

    mode_t            w_mode;
    logic             w_shift_cls;
    logic [WIDTH-1:0] w_live_next;
    logic [WIDTH-1:0] w_burst_next;

    function automatic logic [WIDTH-1:0] f_step(
        input mode_t            m,
        input logic [WIDTH-1:0] v,
        input logic             lft,
        input logic             rgt,
        input logic [WIDTH-1:0] pl
    );
        logic [WIDTH-1:0] n;
        n = v;
        case (m)
            M_SHR:   n = {rgt, v[WIDTH-1:1]};
            M_SHL:   n = {v[WIDTH-2:0], lft};
            M_LOAD:  n = pl;
            M_ROR:   n = {v[0], v[WIDTH-1:1]};
            M_ROL:   n = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ASR:   n = {v[WIDTH-1], v[WIDTH-1:1]};
            default: n = v;
        endcase
        return n;
    endfunction

    assign w_mode = mode_t'(bus.mode);

    always_comb begin
        w_shift_cls = 1'b0;
        case (w_mode)
            M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: w_shift_cls = 1'b1;
            default:                           w_shift_cls = 1'b0;
        endcase
    end

    // Bursts use the latched mode but live serial inputs at every step.
    assign w_live_next  = f_step(w_mode, r_out, bus.lftin, bus.rghtin, bus.pload);
    assign w_burst_next = f_step(r_mode, r_out, bus.lftin, bus.rghtin, bus.pload);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= M_HOLD;
            r_cnt   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_shift_cls) begin
                        r_mode <= w_mode;
                        if (bus.count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= bus.count;
                            r_state <= S_BURST;
                        end
                    end else begin
                        r_out <= w_live_next;
                    end
                end
                S_BURST: begin
                    r_out <= w_burst_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out    = r_out;
    assign bus.busy   = (r_state == S_BURST);
    assign bus.done   = r_done;
    assign bus.sout_r = r_out[0];
    assign bus.sout_l = r_out[WIDTH-1];
endmodule

// File: tb/tb_param_usr.sv
// Self-checking bench for param_usr: directed scenarios plus randomized traffic against an arithmetic model.
module tb_param_usr;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    param_usr_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    param_usr #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: register value, remaining burst steps, burst mode, done flag.
    int m_out  = 0;
    int m_left = 0;
    int m_mode = 0;
    int m_done = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int op(input int md, input int v, input int l, input int r, input int pl);
        case (md)
            1:       return (v >> 1) | (r << (W - 1));
            2:       return ((v << 1) | l) & MASK;
            3:       return pl & MASK;
            4:       return (v >> 1) | ((v & 1) << (W - 1));
            5:       return ((v << 1) & MASK) | (v >> (W - 1));
            6:       return (v >> 1) | (v & (1 << (W - 1)));
            default: return v;
        endcase
    endfunction

    function automatic bit is_shift(input int md);
        return (md == 1) || (md == 2) || (md == 4) || (md == 5) || (md == 6);
    endfunction

    task automatic model_reset();
        m_out  = 0;
        m_left = 0;
        m_mode = 0;
        m_done = 0;
    endtask

    task automatic model_edge();
        int md;
        md     = int'(bus.mode);
        m_done = 0;
        if (m_left > 0) begin
            m_out = op(m_mode, m_out, int'(bus.lftin), int'(bus.rghtin), int'(bus.pload));
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (bus.start && is_shift(md)) begin
            m_mode = md;
            m_left = int'(bus.count);
            if (m_left == 0) m_done = 1;
        end else begin
            m_out = op(md, m_out, int'(bus.lftin), int'(bus.rghtin), int'(bus.pload));
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"},    int'(bus.out),    m_out);
        chk({tag, ".busy"},   int'(bus.busy),   (m_left > 0) ? 1 : 0);
        chk({tag, ".done"},   int'(bus.done),   m_done);
        chk({tag, ".sout_r"}, int'(bus.sout_r), m_out & 1);
        chk({tag, ".sout_l"}, int'(bus.sout_l), (m_out >> (W - 1)) & 1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input int md, input int pl, input int l, input int r, input int st, input int cnt);
        bus.mode   = 3'(md);
        bus.pload  = W'(pl);
        bus.lftin  = l[0];
        bus.rghtin = r[0];
        bus.start  = st[0];
        bus.count  = CW'(cnt);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst.out",  int'(bus.out),  0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;

        // parallel load
        drive(3, 8'hA5, 0, 0, 0, 0);
        tick("load");
        chk("load.A5", int'(bus.out), 8'hA5);

        // shift right with rghtin=1
        drive(1, 0, 0, 1, 0, 0);
        tick("shr1");
        chk("shr1.D2", int'(bus.out), 8'hD2);
        chk("shr1.sout_r", int'(bus.sout_r), 0);
        tick("shr2");
        chk("shr2.E9", int'(bus.out), 8'hE9);
        chk("shr2.sout_r", int'(bus.sout_r), 1);

        // rotate-left burst of 3 from 0x81
        drive(3, 8'h81, 0, 0, 0, 0);
        tick("ld81");
        drive(5, 0, 0, 0, 1, 3);
        tick("rol.acc");
        chk("rol.acc.out", int'(bus.out), 8'h81);
        chk("rol.acc.busy", int'(bus.busy), 1);
        drive(0, 0, 0, 0, 0, 0);
        tick("rol.s1");
        chk("rol.s1.out", int'(bus.out), 8'h03);
        tick("rol.s2");
        chk("rol.s2.out", int'(bus.out), 8'h06);
        tick("rol.s3");
        chk("rol.s3.out", int'(bus.out), 8'h0C);
        chk("rol.s3.done", int'(bus.done), 1);
        chk("rol.s3.busy", int'(bus.busy), 0);
        tick("rol.post");
        chk("rol.post.done", int'(bus.done), 0);
        chk("rol.post.out", int'(bus.out), 8'h0C);

        // arithmetic-shift burst of 7 from 0x80 with a stray start mid-burst
        drive(3, 8'h80, 0, 0, 0, 0);
        tick("ld80");
        drive(6, 0, 0, 0, 1, 7);
        tick("asr.acc");
        for (int i = 0; i < 7; i++) begin
            if (i == 3) drive(3, 8'h00, 1, 1, 1, 2);
            else        drive(0, 0, 0, 0, 0, 0);
            tick("asr.step");
        end
        chk("asr.out", int'(bus.out), 8'hFF);
        chk("asr.done", int'(bus.done), 1);

        // asynchronous reset mid-burst, between edges
        drive(2, 0, 1, 0, 1, 10);
        tick("shl.acc");
        drive(0, 0, 0, 0, 0, 0);
        tick("shl.s1");
        tick("shl.s2");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.out",  int'(bus.out),  0);
        chk("arst.busy", int'(bus.busy), 0);
        chk("arst.done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(3, 8'h3C, 0, 0, 0, 0);
        tick("post_rst");
        chk("post_rst.out", int'(bus.out), 8'h3C);

        // zero-length burst
        drive(3, 8'h5A, 0, 0, 0, 0);
        tick("ld5A");
        drive(1, 0, 0, 1, 1, 0);
        tick("z.acc");
        chk("z.out",  int'(bus.out),  8'h5A);
        chk("z.busy", int'(bus.busy), 0);
        chk("z.done", int'(bus.done), 1);
        drive(0, 0, 0, 0, 0, 0);
        tick("z.post");
        chk("z.post.done", int'(bus.done), 0);

        // non-shift mode with start: single op, no busy, no done
        drive(3, 8'hC3, 0, 0, 1, 5);
        tick("ns.load");
        chk("ns.out", int'(bus.out), 8'hC3);
        chk("ns.busy", int'(bus.busy), 0);

        // randomized traffic, including starts landing on done cycles
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 7), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 15));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
